// File: rtl/sram_arbiter_pkg.sv
// Shared types for the instruction/data SRAM arbiter.
// Holds FSM/owner encodings, bus widths and starvation default.
package sram_arbiter_pkg;

  localparam int AW             = 32;
  localparam int DW             = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_RESP = 1'b1
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Fetch, load/store and SRAM signals of the arbiter.
// master: core/SRAM side, slave: arbiter side.
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
();

  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_ready;
  logic          inst_rvalid;
  logic [DW-1:0] inst_rdata;

  logic          data_req;
  logic          data_wr;
  logic [3:0]    data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_ready;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;

  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_ready, inst_rvalid, inst_rdata,
    output data_req, data_wr, data_wstrb,
    output data_addr, data_wdata,
    input  data_ready, data_rvalid, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_ready, inst_rvalid, inst_rdata,
    input  data_req, data_wr, data_wstrb,
    input  data_addr, data_wdata,
    output data_ready, data_rvalid, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

endinterface

// File: rtl/sram_arb_pick.sv
// Winner selection: data first unless inst is starved.
// In: inst_req, data_req, at_max. Out: grant_inst, grant_data.
module sram_arb_pick (
  input  logic inst_req,
  input  logic data_req,
  input  logic at_max,
  output logic grant_inst,
  output logic grant_data
);

  always_comb begin
    grant_inst = inst_req & (~data_req | at_max);
    grant_data = data_req & ~grant_inst;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates fetch and load/store onto one single-port SRAM.
// Ports: clk, reset (async high), bus (slave modport).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [CW-1:0] starve_cnt, cnt_nxt;
  logic          at_max;
  logic          can_grant;
  logic          grant_inst, grant_data;

  assign at_max    = starve_cnt == CW'(STARVE_MAX);
  assign can_grant = (state == IDLE) & ~reset;

  sram_arb_pick u_pick (
    .inst_req   (bus.inst_req & can_grant),
    .data_req   (bus.data_req & can_grant),
    .at_max     (at_max),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWN_INST;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    cnt_nxt         = starve_cnt;
    bus.inst_ready  = 1'b0;
    bus.inst_rvalid = 1'b0;
    bus.inst_rdata  = '0;
    bus.data_ready  = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = '0;
    bus.sram_en     = 1'b0;
    bus.sram_we     = 4'b0;
    bus.sram_addr   = '0;
    bus.sram_wdata  = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (grant_inst) begin
            bus.inst_ready = 1'b1;
            bus.sram_en    = 1'b1;
            bus.sram_addr  = bus.inst_addr;
            state_nxt      = RD_RESP;
            owner_nxt      = OWN_INST;
            cnt_nxt        = '0;
          end else if (grant_data) begin
            bus.data_ready = 1'b1;
            bus.sram_en    = 1'b1;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
            if (bus.data_wr) begin
              bus.sram_we = bus.data_wstrb;
            end else begin
              state_nxt = RD_RESP;
              owner_nxt = OWN_DATA;
            end
            // Only data grants that bypass a waiting fetch count.
            if (!bus.inst_req)
              cnt_nxt = '0;
            else if (!at_max)
              cnt_nxt = starve_cnt + CW'(1);
          end
        end
        RD_RESP: begin
          state_nxt = IDLE;
          if (owner == OWN_INST) begin
            bus.inst_rvalid = 1'b1;
            bus.inst_rdata  = bus.sram_rdata;
          end else begin
            bus.data_rvalid = 1'b1;
            bus.data_rdata  = bus.sram_rdata;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural model
// and an SRAM environment model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sram_arbiter_if bus ();

  sram_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM environment (what the arbiter talks to)
  logic [31:0] env_mem [logic [31:0]];
  logic        c_en;
  logic [3:0]  c_we;
  logic [31:0] c_addr, c_wd;

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (c_en && c_we == 4'b0) bus.sram_rdata <= env_rd(c_addr);
    else bus.sram_rdata <= $urandom;
    if (c_en && c_we != 4'b0) env_mem[c_addr] = merge(env_rd(c_addr), c_wd, c_we);
  end

  // Behavioural model of the arbitration rules
  logic [31:0] mdl_mem [logic [31:0]];
  bit          m_busy, m_own_data;
  int          m_cnt;
  logic [31:0] m_rdata;
  bit          g_inst, g_data;
  bit          s_ireq, s_dwr;
  logic [31:0] s_iaddr, s_daddr, s_dwd;
  logic [3:0]  s_strb;

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
  endfunction

  always @(negedge clk) begin
    logic        e_ir, e_iv, e_dr, e_dv, e_en;
    logic [31:0] e_id, e_dd, e_addr, e_wd;
    logic [3:0]  e_we;
    {e_ir, e_iv, e_dr, e_dv, e_en} = '0;
    e_id = '0; e_dd = '0; e_addr = '0; e_wd = '0; e_we = '0;
    g_inst = 1'b0;
    g_data = 1'b0;
    if (!reset) begin
      if (m_busy) begin
        if (m_own_data) begin e_dv = 1'b1; e_dd = m_rdata; end
        else begin e_iv = 1'b1; e_id = m_rdata; end
      end else begin
        g_inst = bus.inst_req && (!bus.data_req || m_cnt >= SMAX);
        g_data = bus.data_req && !g_inst;
        if (g_inst) begin
          e_ir = 1'b1; e_en = 1'b1; e_addr = bus.inst_addr;
        end
        if (g_data) begin
          e_dr = 1'b1; e_en = 1'b1;
          e_addr = bus.data_addr; e_wd = bus.data_wdata;
          e_we = bus.data_wr ? bus.data_wstrb : 4'b0;
        end
      end
    end
    chk("inst_ready", 32'(bus.inst_ready), 32'(e_ir));
    chk("inst_rvalid", 32'(bus.inst_rvalid), 32'(e_iv));
    chk("inst_rdata", bus.inst_rdata, e_id);
    chk("data_ready", 32'(bus.data_ready), 32'(e_dr));
    chk("data_rvalid", 32'(bus.data_rvalid), 32'(e_dv));
    chk("data_rdata", bus.data_rdata, e_dd);
    chk("sram_en", 32'(bus.sram_en), 32'(e_en));
    chk("sram_we", 32'(bus.sram_we), 32'(e_we));
    chk("sram_addr", bus.sram_addr, e_addr);
    chk("sram_wdata", bus.sram_wdata, e_wd);
    s_ireq = bus.inst_req; s_iaddr = bus.inst_addr;
    s_dwr = bus.data_wr; s_daddr = bus.data_addr;
    s_dwd = bus.data_wdata; s_strb = bus.data_wstrb;
    c_en = bus.sram_en; c_we = bus.sram_we;
    c_addr = bus.sram_addr; c_wd = bus.sram_wdata;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_cnt = 0;
    end else if (m_busy) begin
      m_busy = 1'b0;
    end else if (g_inst) begin
      m_busy = 1'b1; m_own_data = 1'b0;
      m_rdata = mdl_rd(s_iaddr);
      m_cnt = 0;
    end else if (g_data) begin
      if (s_dwr) mdl_mem[s_daddr] = merge(mdl_rd(s_daddr), s_dwd, s_strb);
      else begin
        m_busy = 1'b1; m_own_data = 1'b1;
        m_rdata = mdl_rd(s_daddr);
      end
      m_cnt = !s_ireq ? 0 : (m_cnt < SMAX ? m_cnt + 1 : SMAX);
    end
  end

  // Stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  int codes [16];
  int e40 [8] = '{1, 1, 1, 1, 2, 0, 1, 1};
  int e43 [5] = '{1, 1, 2, 0, 1};

  // Stores n words from base while optionally holding a fetch;
  // codes[] records who was granted each cycle (1 data, 2 inst).
  task automatic run_stores(input int n, input logic [31:0] base,
                            input bit hold, input int ncyc);
    int s;
    bit drop;
    s = 0;
    bus.inst_req = hold;
    bus.inst_addr = 32'h200;
    for (int c = 0; c < ncyc; c++) begin
      bus.data_req = (s < n);
      bus.data_wr = 1'b1;
      bus.data_wstrb = 4'hF;
      bus.data_addr = base + 32'(4 * s);
      bus.data_wdata = base ^ 32'(s + 1);
      neg();
      codes[c] = bus.data_ready ? 1 : (bus.inst_ready ? 2 : 0);
      if (bus.data_ready) s++;
      drop = bus.inst_ready;
      tick();
      if (drop) bus.inst_req = 1'b0;
    end
    bus.data_req = 1'b0;
  endtask

  initial begin
    bus.inst_req = 1'b0; bus.inst_addr = '0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0;
    bus.data_wstrb = '0; bus.data_addr = '0; bus.data_wdata = '0;
    env_mem[32'h1C000000] = 32'h02800401;
    mdl_mem[32'h1C000000] = 32'h02800401;

    repeat (2) @(posedge clk);
    neg();
    chk("rst_sram_en", 32'(bus.sram_en), 32'h0);
    chk("rst_inst_rvalid", 32'(bus.inst_rvalid), 32'h0);

    // fetch right after reset release
    tick();
    reset = 1'b0;
    bus.inst_req = 1'b1;
    bus.inst_addr = 32'h1C000000;
    neg();
    chk("f_ready_T", 32'(bus.inst_ready), 32'h1);
    chk("f_addr_T", bus.sram_addr, 32'h1C000000);
    tick();
    bus.inst_req = 1'b0;
    neg();
    chk("f_rvalid_T1", 32'(bus.inst_rvalid), 32'h1);
    chk("f_rdata_T1", bus.inst_rdata, 32'h02800401);
    chk("f_ready_T1", 32'(bus.inst_ready), 32'h0);
    tick();

    // simultaneous fetch and load
    bus.inst_req = 1'b1; bus.inst_addr = 32'h100;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1000;
    neg();
    chk("sim_data_first", 32'(bus.data_ready), 32'h1);
    chk("sim_inst_wait", 32'(bus.inst_ready), 32'h0);
    tick();
    bus.data_req = 1'b0;
    neg();
    chk("sim_drvalid", 32'(bus.data_rvalid), 32'h1);
    chk("sim_drdata", bus.data_rdata, 32'hC0FFFE00);
    chk("sim_inst_resp_cyc", 32'(bus.inst_ready), 32'h0);
    tick();
    neg();
    chk("sim_inst_grant", 32'(bus.inst_ready), 32'h1);
    tick();
    bus.inst_req = 1'b0;
    neg();
    chk("sim_irdata", bus.inst_rdata, 32'hC0FFEF00);
    tick();

    // starvation: six stores against a held fetch
    run_stores(6, 32'h3000, 1'b1, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("starve_c%0d", i), 32'(codes[i]), 32'(e40[i]));

    // partial store, then load back with wstrb ignored
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b0011;
    bus.data_addr = 32'h2000; bus.data_wdata = 32'hAABBCCDD;
    neg();
    chk("st_we", 32'(bus.sram_we), 32'h3);
    chk("st_wdata", bus.sram_wdata, 32'hAABBCCDD);
    tick();
    bus.data_req = 1'b0;
    neg();
    chk("st_no_rvalid", 32'(bus.data_rvalid), 32'h0);
    tick();
    bus.data_req = 1'b1; bus.data_wr = 1'b0;
    neg();
    chk("ld_we_zero", 32'(bus.sram_we), 32'h0);
    tick();
    bus.data_req = 1'b0;
    neg();
    chk("ld_merged", bus.data_rdata, 32'hC0FFCCDD);
    tick();

    // reset during the read response cycle
    bus.inst_req = 1'b1; bus.inst_addr = 32'h400;
    tick();
    bus.inst_req = 1'b0;
    #1;
    chk("rr_pending", 32'(bus.inst_rvalid), 32'h1);
    reset = 1'b1;
    #1;
    chk("rr_async_rvalid", 32'(bus.inst_rvalid), 32'h0);
    chk("rr_async_rdata", bus.inst_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    neg();
    chk("rr_no_rvalid", 32'(bus.inst_rvalid), 32'h0);
    tick();
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1000;
    neg();
    chk("rr_next_ready", 32'(bus.data_ready), 32'h1);
    tick();
    bus.data_req = 1'b0;
    neg();
    chk("rr_next_rdata", bus.data_rdata, 32'hC0FFFE00);
    tick();

    // fetch dropped while data wins; counter holds
    run_stores(2, 32'h5000, 1'b1, 2);
    chk("drop_c0", 32'(codes[0]), 32'h1);
    chk("drop_c1", 32'(codes[1]), 32'h1);
    bus.inst_req = 1'b0;
    repeat (2) begin
      neg();
      chk("drop_no_access", 32'(bus.sram_en), 32'h0);
      tick();
    end
    run_stores(3, 32'h6000, 1'b1, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("hold_c%0d", i), 32'(codes[i]), 32'(e43[i]));

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data grants allowed while inst_req is pending before inst is forced.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inst_req  input  1  fetch read request; held with inst_addr until inst_ready.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_ready  output  1  fetch request accepted this cycle.
REQ-007 inst_rvalid  output  1  fetch read data valid, one-cycle pulse.
REQ-008 inst_rdata  output  32  fetch read data.
REQ-009 data_req  input  1  load/store request; held with all data_* inputs until data_ready.
REQ-010 data_wr  input  1  1 = store, 0 = load.
REQ-011 data_wstrb  input  4  store byte enables.
REQ-012 data_addr  input  32  load/store byte address.
REQ-013 data_wdata  input  32  store data.
REQ-014 data_ready  output  1  load/store request accepted this cycle.
REQ-015 data_rvalid  output  1  load data valid, one-cycle pulse; never asserted for stores.
REQ-016 data_rdata  output  32  load data.
REQ-017 sram_en  output  1  unified single-port SRAM access enable.
REQ-018 sram_we  output  4  SRAM byte write enables; 0 for reads.
REQ-019 sram_addr  output  32  SRAM address.
REQ-020 sram_wdata  output  32  SRAM write data.
REQ-021 sram_rdata  input  32  SRAM read data, valid the cycle after a read access (sram_en=1, sram_we=0).

Function
REQ-022 The FSM SHALL have two states: IDLE (grant allowed) and RD_RESP (read data return; no grant).
REQ-023 In IDLE with any request pending, exactly one requester SHALL be granted combinationally: its ready=1, sram_en=1, sram_addr/sram_wdata taken from that requester, sram_we = data_wstrb for a data store and 0 otherwise.
REQ-024 Priority SHALL be data over inst, except that when starve_cnt == STARVE_MAX and inst_req=1, inst SHALL win.
REQ-025 starve_cnt SHALL increment on each data grant made while inst_req=1, clear on any inst grant, clear on any data grant made while inst_req=0, and saturate at STARVE_MAX.
REQ-026 A granted read (inst, or data with data_wr=0) SHALL move IDLE->RD_RESP and record the owner; in RD_RESP the owner's rvalid SHALL be 1 and its rdata SHALL equal sram_rdata; the FSM SHALL then return to IDLE unconditionally.
REQ-027 Read latency SHALL be accepted at cycle T -> rvalid at T+1; read throughput SHALL be one read per 2 cycles.
REQ-028 A granted store SHALL complete in its grant cycle, SHALL stay in IDLE, and SHALL allow back-to-back stores at one per cycle.
REQ-029 In RD_RESP, and in IDLE with no request, inst_ready, data_ready, sram_en, sram_we, sram_addr and sram_wdata SHALL be 0.
REQ-030 inst_rdata and data_rdata SHALL be 0 whenever the matching rvalid is 0.
REQ-031 A requester that drops req before ready SHALL cause no SRAM access and no counter change.
REQ-032 On simultaneous requests, the loser's request SHALL stay pending with no state change for it; no request SHALL be lost or duplicated.
REQ-033 data_wstrb SHALL be ignored when data_wr=0.

Reset
REQ-034 Reset assertion SHALL immediately force state=IDLE, starve_cnt=0, owner=inst, and all outputs to 0, including mid-RD_RESP, where the pending rvalid is dropped.
REQ-035 The first grant after reset deassertion SHALL be possible in the first clk edge cycle.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the owner encoding (INST/DATA), the default STARVE_MAX, and the 32-bit address/data widths.
REQ-037 One sub-module, sram_arb_pick, SHALL contain the combinational winner selection (inputs: inst_req, data_req, starve_cnt at max; outputs: grant_inst, grant_data). All state SHALL remain in sram_arbiter.

Verification
REQ-038 Apply inst_req, addr 0x1C000000, with the SRAM returning 0x02800401 -> inst_ready at T; inst_rvalid=1 with inst_rdata=0x02800401 at T+1; ready=0 at T+1.
REQ-039 Raise inst_req and a data load to 0x1000 in the same cycle -> data granted first; inst granted at the first IDLE cycle after data_rvalid.
REQ-040 Hold inst_req while issuing 6 back-to-back stores -> stores 1-4 granted one per cycle; the 5th cycle grants inst; the remaining stores follow.
REQ-041 Store 0xAABBCCDD, wstrb 0b0011, to 0x2000 -> sram_we=0011 and sram_wdata=0xAABBCCDD in the grant cycle; no data_rvalid.
REQ-042 Assert reset in the RD_RESP cycle -> all outputs 0 asynchronously; no rvalid after release; the next request is served normally.
REQ-043 Drop inst_req before a grant while data wins -> no inst access and starve_cnt unchanged from the drop onward.
